// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - line buffer that turns a raster pixel stream into HEIGHT_NB-tall columns
// Optional up_sof frame restart input is enabled with macro LINE_BUFFER_SOF_EN.
module line_buffer #(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 8,
  parameter int LINE_MAX  = 1024,
  parameter int LEN_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN_WIDTH-1:0]           cfg_len,
  input  logic                           cfg_val,
  input  logic [IMG_WIDTH-1:0]           up_pix,
  input  logic                           up_val,
`ifdef LINE_BUFFER_SOF_EN
  input  logic                           up_sof,
`endif
  output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
  output logic                           dn_val
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int LW = $clog2(LINE_MAX + 1);
  localparam int NW = (HEIGHT_NB > 1) ? $clog2(HEIGHT_NB) : 1;
  localparam logic [LW-1:0] LEN_MAX    = LW'(LINE_MAX);
  localparam logic [NW-1:0] LINES_FULL = NW'(HEIGHT_NB - 1);

  logic [LW-1:0] len_q;
  logic [LW-1:0] col_q;
  logic [NW-1:0] lines_q;
  logic          accept;
  logic          sof;
  logic [LW-1:0] eff_col;
  logic [NW-1:0] eff_lines;
  logic [AW-1:0] addr;
  logic          col_last;
  logic          primed;
  logic [HEIGHT_NB-1:0][IMG_WIDTH-1:0] col_pix;

`ifdef LINE_BUFFER_SOF_EN
  assign sof = up_sof;
`else
  assign sof = 1'b0;
`endif

  assign accept    = up_val & ~cfg_val;
  // A start-of-frame pixel is handled as if the counters were already cleared.
  assign eff_col   = sof ? '0 : col_q;
  assign eff_lines = sof ? '0 : lines_q;
  assign addr      = eff_col[AW-1:0];
  assign col_last  = (eff_col == len_q - LW'(1));
  assign primed    = (eff_lines == LINES_FULL);
  assign col_pix[0] = up_pix;

  // Memory k is read into column slot k+1 and refilled from slot k, forming a vertical shift chain.
  for (genvar k = 0; k < HEIGHT_NB - 1; k++) begin : g_line
    logic [IMG_WIDTH-1:0] mem [LINE_MAX];

    assign col_pix[k+1] = mem[addr];

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[addr] <= col_pix[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= LEN_MAX;
      col_q   <= '0;
      lines_q <= '0;
      dn_val  <= 1'b0;
      dn_img  <= '0;
    end else if (cfg_val) begin
      len_q   <= (cfg_len == '0 || 32'(cfg_len) > LINE_MAX) ? LEN_MAX : LW'(cfg_len);
      col_q   <= '0;
      lines_q <= '0;
      dn_val  <= 1'b0;
    end else if (up_val) begin
      dn_img <= col_pix;
      dn_val <= primed;
      if (col_last) begin
        col_q   <= '0;
        lines_q <= primed ? eff_lines : eff_lines + NW'(1);
      end else begin
        col_q   <= eff_col + LW'(1);
        lines_q <= eff_lines;
      end
    end else begin
      dn_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// tb/tb_line_buffer.sv - scoreboard bench for line_buffer with a pixel-history reference model
module tb_line_buffer;
  localparam int H    = 3;
  localparam int W    = 8;
  localparam int LM   = 8;
  localparam int LENW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [LENW-1:0] cfg_len = '0;
  logic           cfg_val = 1'b0;
  logic [W-1:0]   up_pix = '0;
  logic           up_val = 1'b0;
  logic           up_sof = 1'b0;
  logic [H*W-1:0] dn_img;
  logic           dn_val;

  line_buffer #(.HEIGHT_NB(H), .IMG_WIDTH(W), .LINE_MAX(LM), .LEN_WIDTH(LENW)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_val(cfg_val),
    .up_pix(up_pix), .up_val(up_val),
`ifdef LINE_BUFFER_SOF_EN
    .up_sof(up_sof),
`endif
    .dn_img(dn_img), .dn_val(dn_val)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int len_m = LM;
  logic [W-1:0]   hist[$];
  logic [H*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pixel i since the last re-prime sits at column i%len of line i/len;
  // its column holds the pixels exactly h lines (h*len pixels) earlier.
  task automatic step(input logic v, input logic [W-1:0] p, input logic c, input int l, input logic s);
    logic [H*W-1:0] e;
    int i;
    up_val = v; up_pix = p; cfg_val = c; cfg_len = LENW'(l); up_sof = s;
    if (c) begin
      len_m = (l == 0 || l > LM) ? LM : l;
      hist.delete();
    end else if (v) begin
      if (s) hist.delete();
      i = hist.size();
      hist.push_back(p);
      if (i / len_m >= H - 1) begin
        for (int h = 0; h < H; h++) e[h*W +: W] = hist[i - h*len_m];
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    up_val = 1'b0; cfg_val = 1'b0; up_sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; up_val = 1'b0; cfg_val = 1'b0; up_sof = 1'b0;
    hist.delete();
    len_m = LM;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pixels(input int first, input int last);
    for (int p = first; p <= last; p++) step(1'b1, W'(p), 1'b0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (dn_val) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got dn_val=1 dn_img=%0h expected no output", dn_img);
      end else begin
        logic [H*W-1:0] e;
        e = exp_q.pop_front();
        if (dn_img !== e) begin
          fails++;
          $display("FAIL sb_column: got %0h expected %0h", dn_img, e);
        end
      end
    end
  end

  initial begin
    int r;
    int lens[9];
    lens = '{0, 1, 2, 3, 4, 5, 8, 9, 20};

    do_reset();
    check("reset_dn_val", 32'(dn_val), 32'd0);
    check("reset_dn_img", 32'(dn_img), 32'd0);

    // Priming and column wrap
    step(1'b0, '0, 1'b1, 4, 1'b0);
    pixels(1, 8);
    check("prime_p8_val", 32'(dn_val), 32'd0);
    pixels(9, 9);
    check("prime_p9_val", 32'(dn_val), 32'd1);
    check("prime_p9_img", 32'(dn_img), 32'h010509);
    pixels(10, 12);
    check("wrap_p12_img", 32'(dn_img), 32'h04080c);
    pixels(13, 13);
    check("wrap_p13_img", 32'(dn_img), 32'h05090d);
    step(1'b0, '0, 1'b0, 0, 1'b0);
    check("idle_dn_val", 32'(dn_val), 32'd0);
    check("idle_hold_img", 32'(dn_img), 32'h05090d);

    // Gapped input
    step(1'b0, '0, 1'b1, 4, 1'b0);
    for (int p = 1; p <= 13; p++) begin
      step(1'b1, W'(p), 1'b0, 0, 1'b0);
      if (p == 9) check("gap_p9_img", 32'(dn_img), 32'h010509);
      step(1'b0, '0, 1'b0, 0, 1'b0);
      if (p == 9) check("gap_idle_val", 32'(dn_val), 32'd0);
    end
    check("gap_p13_img", 32'(dn_img), 32'h05090d);

    // cfg_val beats up_val, pixel 10 dropped and priming restarts
    step(1'b0, '0, 1'b1, 4, 1'b0);
    pixels(1, 9);
    step(1'b1, 8'd10, 1'b1, 4, 1'b0);
    check("conflict_val", 32'(dn_val), 32'd0);
    pixels(11, 18);
    check("conflict_p18_val", 32'(dn_val), 32'd0);
    pixels(19, 19);
    check("conflict_p19_img", 32'(dn_img), 32'h0b0f13);

    // Length clamp
    step(1'b0, '0, 1'b1, 0, 1'b0);
    pixels(1, 16);
    check("clamp0_p16_val", 32'(dn_val), 32'd0);
    pixels(17, 17);
    check("clamp0_p17_img", 32'(dn_img), 32'h010911);
    step(1'b0, '0, 1'b1, 20, 1'b0);
    pixels(1, 16);
    check("clamp20_p16_val", 32'(dn_val), 32'd0);
    pixels(17, 17);
    check("clamp20_p17_img", 32'(dn_img), 32'h010911);

    // Reset mid-line
    step(1'b0, '0, 1'b1, 4, 1'b0);
    pixels(1, 6);
    do_reset();
    check("rst_mid_val", 32'(dn_val), 32'd0);
    check("rst_mid_img", 32'(dn_img), 32'd0);
    step(1'b0, '0, 1'b1, 4, 1'b0);
    pixels(101, 108);
    check("rst_p8_val", 32'(dn_val), 32'd0);
    pixels(109, 109);
    check("rst_p9_img", 32'(dn_img), 32'h65696d);

`ifdef LINE_BUFFER_SOF_EN
    step(1'b0, '0, 1'b1, 4, 1'b0);
    pixels(1, 10);
    step(1'b1, 8'd11, 1'b0, 0, 1'b1);
    check("sof_p11_val", 32'(dn_val), 32'd0);
    pixels(12, 18);
    check("sof_p18_val", 32'(dn_val), 32'd0);
    pixels(19, 19);
    check("sof_p19_img", 32'(dn_img), 32'h0b0f13);
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        do_reset();
      end else if (r < 20) begin
        step(($urandom_range(0, 1) == 1), W'($urandom), 1'b1, lens[$urandom_range(0, 8)], 1'b0);
      end else begin
`ifdef LINE_BUFFER_SOF_EN
        step(($urandom_range(0, 9) < 7), W'($urandom), 1'b0, 0, ($urandom_range(0, 99) == 0));
`else
        step(($urandom_range(0, 9) < 7), W'($urandom), 1'b0, 0, 1'b0);
`endif
      end
    end
    step(1'b0, '0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 1'b0, 0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 SHALL have parameter HEIGHT_NB, default 3: rows per output column; matches the downstream filter's row count.
REQ-002 SHALL have parameter IMG_WIDTH, default 8: pixel width in bits.
REQ-003 SHALL have parameter LINE_MAX, default 1024: maximum pixels per line, which sets the depth of each line memory.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of cfg_len.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port cfg_len, input, LEN_WIDTH bits: line length in pixels.
REQ-008 SHALL have port cfg_val, input, 1 bit: load strobe for cfg_len.
REQ-009 SHALL have port up_pix, input, IMG_WIDTH bits: raster-order input pixel.
REQ-010 SHALL have port up_val, input, 1 bit: up_pix valid; there is no backpressure.
REQ-011 SHALL have port dn_img, output, HEIGHT_NB*IMG_WIDTH bits: vertical pixel column; slice h is the pixel from h lines earlier, and slice 0 is the newest.
REQ-012 SHALL have port dn_val, output, 1 bit: dn_img valid; connects directly to the filter's up_val.

Function
REQ-013 SHALL hold HEIGHT_NB-1 line memories of LINE_MAX x IMG_WIDTH; memory k holds the line k+1 lines back.
REQ-014 SHALL maintain a column counter col (0..len-1) and a line counter lines (saturating at HEIGHT_NB-1).
REQ-015 On accepting a pixel (up_val=1, cfg_val=0) at column col, SHALL register dn_img slice 0 = up_pix and slice h = memory h-1[col] for h>=1.
REQ-016 In the same cycle, SHALL write memory 0[col] = up_pix and memory k[col] = memory k-1[col] (read-before-write).
REQ-017 SHALL give latency exactly 1 cycle: dn_img and dn_val update on the edge after the accepted pixel.
REQ-018 SHALL assert dn_val for one cycle per accepted pixel only when lines == HEIGHT_NB-1 at acceptance; otherwise dn_val=0 (priming).
REQ-019 SHALL hold dn_img and set dn_val=0 in cycles with up_val=0; idle gaps do not disturb the counters.
REQ-020 Column wrap: at col == len-1 the counter SHALL return to 0 and lines SHALL increment, saturating at HEIGHT_NB-1.
REQ-021 On cfg_val=1, SHALL set len = cfg_len, clamped to LINE_MAX when cfg_len is 0 or greater than LINE_MAX, and clear col, lines and dn_val (re-prime).
REQ-022 When cfg_val and up_val are simultaneous, cfg_val SHALL win and the pixel SHALL be dropped.
REQ-023 With HEIGHT_NB=1, SHALL instantiate no memories and pass pixels straight through with 1-cycle latency, dn_val following up_val.

Reset
REQ-024 rst SHALL force len=LINE_MAX, col=0, lines=0, dn_val=0 and dn_img=0.
REQ-025 rst SHALL NOT clear the line memory contents; priming guarantees stale data is never marked valid.
REQ-026 rst mid-line SHALL abandon the partial line; the next accepted pixel is column 0 of a new priming sequence.

Configuration
REQ-027 With macro LINE_BUFFER_SOF_EN defined, the module SHALL add input port up_sof (1 bit).
REQ-028 With LINE_BUFFER_SOF_EN defined, an accepted pixel with up_sof=1 SHALL be treated as col=0 with lines=0, restarting priming and consuming the pixel normally.
REQ-029 Without LINE_BUFFER_SOF_EN, the up_sof port SHALL be absent and the counters free-run across frames.

Verification
(Each scenario uses HEIGHT_NB=3, LINE_MAX=8, cfg_len=4 loaded after reset, and pixels valued 1,2,3,... unless stated otherwise.)
REQ-030 Priming: pixels 1..8 -> dn_val=0 throughout; pixel 9 -> next cycle dn_val=1, dn_img={s2=1,s1=5,s0=9}.
REQ-031 Column wrap: pixel 12 -> {4,8,12}; pixel 13 -> {5,9,13}; dn_val is high one cycle per pixel from pixel 9 onward.
REQ-032 Gaps and conflict: up_val toggled 1/0 gives the same columns as REQ-031 with dn_val=0 in gap cycles; cfg_val with up_val on pixel 10 drops it and re-primes, so dn_val=0 for the next 8 pixels.
REQ-033 Clamp and reset: cfg_len=0 gives the first dn_val on pixel 17; cfg_len=20 behaves identically; rst after pixel 6 gives the first dn_val on the 9th pixel after reset.
REQ-034 SOF (LINE_BUFFER_SOF_EN defined): up_sof on pixel 11 -> dn_val=0 for pixels 11..18; pixel 19 -> {11,15,19}. A build without the macro has no up_sof port.
